// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 SCCB power-up configuration sequencer.
// The soft-reset prologue is selected by CAM_SCCB_SOFT_RESET_EN in cam_sccb_config.sv.
package cam_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SRST_WR,
    SRST_WAIT,
    LOAD,
    START,
    SHIFT,
    STOP,
    GAP,
    DONE
  } sccb_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] val;
  } sccb_entry_t;

  localparam logic [15:0] SCCB_END        = 16'hFFFF;
  localparam logic [7:0]  OV7670_COM7     = 8'h12;
  localparam logic [7:0]  COM7_SOFT_RESET = 8'h80;

  // Don't-care bits are 1 so the open-drain line is released for the ACK slot.
  function automatic logic [26:0] sccb_frame(input logic [7:0] dev, input sccb_entry_t e);
    return {dev, 1'b1, e.reg_addr, 1'b1, e.val, 1'b1};
  endfunction

endpackage

// File: rtl/cam_sccb_config_if.sv
// Control/status bundle between the camera configuration sequencer and its host.
// start is a single-cycle request pulse (no ready); it is taken only when busy is low.
interface cam_sccb_config_if;
  import cam_pkg::*;

  logic        start;
  logic        sioc;
  logic        siod_oe;
  logic        busy;
  logic        done;
  logic [7:0]  reg_count;
  sccb_state_t dbg_state;

  modport master (
    input  start,
    output sioc, siod_oe, busy, done, reg_count, dbg_state
  );

  modport slave (
    output start,
    input  sioc, siod_oe, busy, done, reg_count, dbg_state
  );
endinterface

// File: rtl/ov7670_reg_rom.sv
// OV7670 register table for RGB565 VGA output; 16'hFFFF terminates the table.
module ov7670_reg_rom
  import cam_pkg::*;
(
  input  logic [7:0]  addr,
  output sccb_entry_t entry
);

  always_comb begin
    case (addr)
      8'd0:    entry = {8'h12, 8'h04};
      8'd1:    entry = {8'h40, 8'hD0};
      8'd2:    entry = {8'h11, 8'h01};
      8'd3:    entry = {8'h8C, 8'h00};
      8'd4:    entry = {8'h3A, 8'h04};
      default: entry = SCCB_END;
    endcase
  end

endmodule

// File: rtl/cam_sccb_config.sv
// Walks the OV7670 register table and issues SCCB 3-phase writes on SIOC/SIOD.
// Define CAM_SCCB_SOFT_RESET_EN to prefix each run with a COM7 soft reset and settle wait.
module cam_sccb_config
  import cam_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          SCCB_HZ      = 100_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int          GAP_Q        = 4,
  parameter int          RST_WAIT_CYC = 50_000
) (
  input logic              Clk,
  input logic              Reset,
  cam_sccb_config_if.master bus
);

  localparam int Q  = CLK_HZ / (4 * SCCB_HZ);
  localparam int QW = $clog2(Q + 1);
  localparam int WW = $clog2(RST_WAIT_CYC + 2);

  sccb_state_t   state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [7:0]    quarter_q, quarter_d;
  logic [4:0]    bit_q, bit_d;
  logic [26:0]   shreg_q, shreg_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          sioc_q, sioc_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          srst_q, srst_d;
  logic          last_q, last_d;

  logic          qend;
  logic          begin_run;
  logic          do_lookup;
  logic [7:0]    rom_addr;
  sccb_entry_t   rom_entry;

  assign qend     = (qcnt_q == QW'(Q - 1));
  assign rom_addr = (state_q == LOAD) ? cnt_q : 8'd0;

  ov7670_reg_rom u_rom (
    .addr  (rom_addr),
    .entry (rom_entry)
  );

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qend ? '0 : qcnt_q + QW'(1);
    quarter_d = quarter_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    wait_d    = wait_q;
    sioc_d    = sioc_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    srst_d    = srst_q;
    last_d    = last_q;
    begin_run = 1'b0;
    do_lookup = 1'b0;

    case (state_q)
      IDLE: begin_run = 1'b1;
      DONE: begin_run = bus.start;
      SRST_WR: begin
        state_d = START;
        shreg_d = sccb_frame(DEV_ADDR, {OV7670_COM7, COM7_SOFT_RESET});
        srst_d  = 1'b1;
        sioc_d  = 1'b1;
        oe_d    = 1'b1;
      end
      SRST_WAIT: begin
        if (wait_q == WW'(RST_WAIT_CYC - 1)) state_d = LOAD;
        else                                 wait_d  = wait_q + WW'(1);
      end
      LOAD: do_lookup = 1'b1;
      START: if (qend) begin
        if (quarter_q == 8'd0) begin
          quarter_d = 8'd1;
          sioc_d    = 1'b0;
        end else begin
          state_d = SHIFT;
          bit_d   = 5'd0;
          oe_d    = ~shreg_q[26];
          shreg_d = shreg_q << 1;
        end
      end
      SHIFT: if (qend) begin
        case (quarter_q)
          8'd0: quarter_d = 8'd1;
          8'd1: begin
            quarter_d = 8'd2;
            sioc_d    = 1'b1;
          end
          8'd2: quarter_d = 8'd3;
          default: begin
            // SIOD moves on the same edge SIOC falls, i.e. it is updated while SIOC is low.
            sioc_d = 1'b0;
            if (bit_q == 5'd26) begin
              state_d = STOP;
              oe_d    = 1'b1;
            end else begin
              bit_d     = bit_q + 5'd1;
              quarter_d = 8'd0;
              oe_d      = ~shreg_q[26];
              shreg_d   = shreg_q << 1;
            end
          end
        endcase
      end
      STOP: if (qend) begin
        case (quarter_q)
          8'd0: begin
            quarter_d = 8'd1;
            sioc_d    = 1'b1;
          end
          8'd1: begin
            quarter_d = 8'd2;
            oe_d      = 1'b0;
          end
          default: begin
            if (srst_q) begin
              state_d = SRST_WAIT;
              srst_d  = 1'b0;
            end else begin
              state_d = GAP;
              // Entry 255 is the last the 8-bit index can reach; the count saturates there.
              last_d  = (cnt_q == 8'hFF);
              cnt_d   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            end
          end
        endcase
      end
      GAP: if (qend) begin
        if (quarter_q == 8'(GAP_Q - 1)) begin
          if (last_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          quarter_d = quarter_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (begin_run) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      cnt_d  = 8'd0;
      last_d = 1'b0;
      srst_d = 1'b0;
`ifdef CAM_SCCB_SOFT_RESET_EN
      state_d = SRST_WR;
`else
      do_lookup = 1'b1;
`endif
    end

    // From IDLE/DONE the table lookup happens in the start cycle so SIOD falls with busy.
    if (do_lookup) begin
      if (rom_entry == SCCB_END) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = START;
        shreg_d = sccb_frame(DEV_ADDR, rom_entry);
        sioc_d  = 1'b1;
        oe_d    = 1'b1;
      end
    end

    if (state_d != state_q) begin
      qcnt_d    = '0;
      quarter_d = 8'd0;
      wait_d    = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      quarter_q <= 8'd0;
      bit_q     <= 5'd0;
      shreg_q   <= '0;
      wait_q    <= '0;
      sioc_q    <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 8'd0;
      srst_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      wait_q    <= wait_d;
      sioc_q    <= sioc_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      srst_q    <= srst_d;
      last_q    <= last_d;
    end
  end

  assign bus.sioc      = sioc_q;
  assign bus.siod_oe   = oe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reg_count = cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cam_sccb_config.sv
// Bench for cam_sccb_config: decodes SCCB frames off SIOC/SIOD against an expected queue.
// Runs at a reduced bit-rate ratio (Q = 5 clocks) to keep runs short.
module tb_cam_sccb_config;
  import cam_pkg::*;

  localparam int CLK_HZ    = 50_000_000;
  localparam int SCCB_HZ   = 2_500_000;
  localparam int Q         = CLK_HZ / (4 * SCCB_HZ);
  localparam int GAP_Q     = 4;
  localparam int RST_WAIT  = 200;
  localparam int ENTRY_CYC = (2 + 27 * 4 + 3 + GAP_Q) * Q + 1;
`ifdef CAM_SCCB_SOFT_RESET_EN
  localparam int RUN_CYC        = 2 + (2 + 27 * 4 + 3) * Q + RST_WAIT + 5 * ENTRY_CYC;
  localparam int FRAMES_PER_RUN = 6;
`else
  localparam int RUN_CYC        = 5 * ENTRY_CYC;
  localparam int FRAMES_PER_RUN = 5;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_sccb_config_if bus ();

  cam_sccb_config #(
    .CLK_HZ       (CLK_HZ),
    .SCCB_HZ      (SCCB_HZ),
    .DEV_ADDR     (8'h42),
    .GAP_Q        (GAP_Q),
    .RST_WAIT_CYC (RST_WAIT)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int frames_seen = 0;
  logic [26:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] mk(input logic [7:0] r, input logic [7:0] v);
    return {8'h42, 1'b1, r, 1'b1, v, 1'b1};
  endfunction

  task automatic push_run();
`ifdef CAM_SCCB_SOFT_RESET_EN
    exp_q.push_back(mk(8'h12, 8'h80));
`endif
    exp_q.push_back(mk(8'h12, 8'h04));
    exp_q.push_back(mk(8'h40, 8'hD0));
    exp_q.push_back(mk(8'h11, 8'h01));
    exp_q.push_back(mk(8'h8C, 8'h00));
    exp_q.push_back(mk(8'h3A, 8'h04));
  endtask

  // SCCB line monitor and scoreboard
  logic        prev_sioc, prev_oe, prev_rst;
  logic [26:0] frame;
  int          nbits = 0;
  bit          in_frame = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      nbits    = 0;
    end else if (!prev_rst) begin
      if (bus.siod_oe !== prev_oe)
        check("siod_change_only_sioc_low",
              (bus.sioc === 1'b0) ||
              (bus.siod_oe === 1'b1 && bus.dbg_state == START) ||
              (bus.siod_oe === 1'b0 && bus.dbg_state == STOP), 1);
      if (prev_sioc === 1'b1 && bus.sioc === 1'b1 && prev_oe === 1'b0 && bus.siod_oe === 1'b1) begin
        in_frame = 1;
        nbits    = 0;
      end else if (in_frame && prev_sioc === 1'b0 && bus.sioc === 1'b1) begin
        frame = {frame[25:0], ~bus.siod_oe};
        nbits++;
        if (nbits == 27) begin
          in_frame = 0;
          frames_seen++;
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("frame_bits", frame, exp_q.pop_front());
        end
      end
    end
    prev_sioc = bus.sioc;
    prev_oe   = bus.siod_oe;
    prev_rst  = rst;
  end

  // driver: run until done, optionally pulsing start at a given cycle
  task automatic run_to_done(input string tag, input int pulse_at);
    int         cyc = 0;
    logic [7:0] last_cnt = 8'd0;
    while (bus.done !== 1'b1 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == pulse_at);
      if (bus.reg_count !== last_cnt) begin
        check("reg_count_step", bus.reg_count, last_cnt + 8'd1);
        check("reg_count_in_gap", bus.dbg_state, GAP);
        last_cnt = bus.reg_count;
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_cycle"}, cyc, RUN_CYC);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy_low"}, bus.busy, 0);
    check({tag, "_reg_count"}, bus.reg_count, 5);
    check({tag, "_sioc_idle"}, bus.sioc, 1);
    check({tag, "_siod_released"}, bus.siod_oe, 0);
    check({tag, "_state_done"}, bus.dbg_state, DONE);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int guard;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sioc", bus.sioc, 1);
    check("rst_siod_oe", bus.siod_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_reg_count", bus.reg_count, 0);
    check("rst_state", bus.dbg_state, IDLE);

    // auto-start after reset release, with an ignored start pulse mid-run
    push_run();
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_release", bus.busy, 1);
`ifndef CAM_SCCB_SOFT_RESET_EN
    check("first_siod_fall", bus.siod_oe, 1);
`endif
    run_to_done("run1", 1000);

    // start from DONE, then Reset during entry 2's shift
    push_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_busy", bus.busy, 1);
    check("restart_done_low", bus.done, 0);
    check("restart_reg_count", bus.reg_count, 0);
    guard = 0;
    while (!(bus.reg_count == 8'd2 && bus.dbg_state == SHIFT) && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_entry2_shift", guard < 10000, 1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sioc", bus.sioc, 1);
    check("midrst_siod_oe", bus.siod_oe, 0);
    check("midrst_reg_count", bus.reg_count, 0);
    check("midrst_busy", bus.busy, 0);
    @(negedge clk);
    exp_q.delete();
    push_run();
    rst = 1'b0;
    @(negedge clk);
    check("rerun_busy", bus.busy, 1);
    run_to_done("run3", 0);

    check("frames_total", frames_seen, 2 * FRAMES_PER_RUN + (FRAMES_PER_RUN - 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_sccb_config.md
# cam_sccb_config

Power-up configuration sequencer for the OV7670 camera on the Arduino header. It walks a register table and issues SCCB 3-phase writes on SIOC/SIOD so that `camera_read` receives RGB565 VGA frames. It replaces the currently undriven SIOC/SIOD lines. SIOD is open-drain: the top level drives `ARDUINO_IO[14]` low when `siod_oe` is high and `1'bz` otherwise; SIOC is push-pull.

## Interface
- `CLK_HZ`, 50_000_000, frequency of `Clk`.
- `SCCB_HZ`, 100_000, SIOC bit rate. Quarter-bit tick Q = CLK_HZ/(4*SCCB_HZ) = 125 cycles.
- `DEV_ADDR`, 8'h42, 7-bit ID plus write bit.
- `GAP_Q`, 4, idle quarters between transactions.
- `RST_WAIT_CYC`, 50_000, settle time after soft reset (1 ms).
- `Clk` in 1: MAX10_CLK1_50.
- `Reset` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: pulse that (re)runs the table; honoured only in IDLE or DONE.
- `sioc` out 1: SCCB clock.
- `siod_oe` out 1: 1 pulls SIOD low, 0 releases it.
- `busy` out 1: high from the cycle after an accepted `start` until DONE.
- `done` out 1: high in DONE until the next accepted `start` or `Reset`.
- `reg_count` out 8: number of table writes completed in the current run.

## Operation
- Reset values: `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `reg_count`=0; state IDLE.
- Auto-start: the first cycle after `Reset` deasserts acts as an accepted `start`.
- States:
  - IDLE
  - [SRST_WR, SRST_WAIT]
  - LOAD
  - START
  - SHIFT
  - STOP
  - GAP
  - DONE
- LOAD reads ROM entry `{reg[7:0], val[7:0]}` at `reg_count`.
  - Entry 16'hFFFF goes to DONE.
  - Any other entry goes to START.
- Transaction: 27 bits = `DEV_ADDR`, X, `reg`, X, `val`, X. Bits are MSB first. The X (9th) bit is released (`siod_oe`=0) and not sampled.
- START is 2 quarters:
  - q0: SIOD low, SIOC high.
  - q1: SIOC low.
- SHIFT, per bit, 4 quarters:
  - q0: SIOC low; SIOD updated at the q0 edge.
  - q1: SIOC low.
  - q2, q3: SIOC high.
- STOP is 3 quarters:
  - q0: SIOC low, SIOD low.
  - q1: SIOC high.
  - q2: SIOD released.
- After STOP, `reg_count` increments. The block then spends `GAP_Q` quarters in GAP, then returns to LOAD.
- Table lookup is 8-bit indexed. If index 255 is reached without an end marker, the block goes to DONE after writing it.
- Reset mid-transaction: lines return to idle on the next edge. No STOP is generated, and the sequence restarts from entry 0.
- `start` while `busy` is ignored; no queueing.

## Timing
- Quarter tick is a free counter 0..Q-1, cleared on every state entry. All line changes are registered.
- Transaction length: (2 + 108 + 3) × Q = 14125 cycles. With the gap, one entry takes 14625 cycles.
- `busy` rises 1 cycle after `start`. The first SIOD fall happens on that same edge.
- `done` rises 1 cycle after LOAD sees the end marker; `busy` falls on the same edge.
- `reg_count` updates on the STOP→GAP transition.

## Configuration
- `CAM_SCCB_SOFT_RESET_EN` defined:
  - Each run begins with SRST_WR, a write of COM7 (0x12) = 0x80.
  - SRST_WAIT then idles `RST_WAIT_CYC` cycles before LOAD at entry 0.
  - `reg_count` does not count this write.
- Undefined: the run goes straight to LOAD; SRST states are absent.

## Structure
- Package `cam_pkg`:
  - `sccb_state_t` enum.
  - `SCCB_END` = 16'hFFFF.
  - `OV7670_COM7` = 8'h12.
  - Entry type `sccb_entry_t` {reg, val}.
- Sub-module `ov7670_reg_rom`: combinational 8-bit address → 16-bit entry. Table begins:
  - 12/04: RGB
  - 40/D0: RGB565, full range
  - 11/01: CLKRC
  - 8C/00
  - 3A/04
  - FFFF: end

## Test plan
- Reset release → `busy`=1 next cycle. First byte on SIOD sampled at SIOC rising edges is 0x42, then bytes 0x12, 0x04.
- Full run → `done`=1 and `reg_count`=5 after 5×14625 cycles (macro off). `sioc`=1 and `siod_oe`=0 in DONE.
- `start` pulsed mid-run at cycle 20000 → ignored; `reg_count` sequence and final timing are unchanged.
- `Reset` asserted in SHIFT of entry 2 → next cycle `sioc`=1, `siod_oe`=0, `reg_count`=0. The rerun starts again with 0x42/0x12/0x04.
- Macro on → first transaction writes 12/80. That is followed by ≥50_000 idle cycles, then 12/04; `reg_count` ends at 5.
- SIOD changes only while SIOC is low, except the START fall and STOP release, which occur with SIOC high. Checked by assertion over a whole run.
